// File: rtl/fp_pkg.sv
// Shared float-format constants, status codes and converter states.
// Used by int_to_fp_converter and fp_pack.
package fp_pkg;

   localparam int FP_EXP_W   = 6;
   localparam int FP_FRAC_W  = 25;
   localparam int FP_EXP_MAX = 63;

   typedef enum logic [3:0] {
      ST_EXACT     = 4'd0,
      ST_OVERFLOW  = 4'd1,
      ST_UNDERFLOW = 4'd2,
      ST_INEXACT   = 4'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ABS,
      S_NORM,
      S_PACK
   } cvt_state_e;

endpackage

// File: rtl/fp_pack.sv
// Combinational packer: normalised magnitude -> float word + status.
// Ports: sign, mag (MSB set unless zero), shift_cnt -> data, status.
// Build option ROUND_NEAREST_EN: round-to-nearest-even instead of truncate.
module fp_pack
   import fp_pkg::*;
#(
   parameter int BIAS = 31
) (
   input  logic        sign,
   input  logic [31:0] mag,
   input  logic [4:0]  shift_cnt,
   output logic [31:0] data,
   output status_e     status
);

   logic [6:0]  exp_raw;
   logic [6:0]  exp_fin;
   logic [24:0] frac;
   logic        lost;
`ifdef ROUND_NEAREST_EN
   logic        rnd;
   logic [25:0] frac_sum;
`endif

   always_comb begin
      lost    = |mag[5:0];
      // 7 bits wide so BIAS+31 never wraps before the range check
      exp_raw = 7'(BIAS) + 7'd31 - {2'b00, shift_cnt};
`ifdef ROUND_NEAREST_EN
      // guard=mag[5], sticky=|mag[4:0], ties go to even lsb
      rnd      = mag[5] & ((|mag[4:0]) | mag[6]);
      frac_sum = {1'b0, mag[30:6]} + 26'(rnd);
      if (frac_sum[25]) begin
         frac    = '0;
         exp_fin = exp_raw + 7'd1;
      end else begin
         frac    = frac_sum[24:0];
         exp_fin = exp_raw;
      end
`else
      frac    = mag[30:6];
      exp_fin = exp_raw;
`endif
      data   = '0;
      status = ST_EXACT;
      if (mag == '0) begin
         data   = '0;
         status = ST_EXACT;
      end else if (exp_fin >= 7'(FP_EXP_MAX)) begin
         data   = {sign, 6'h3F, 25'h0};
         status = ST_OVERFLOW;
      end else if (exp_fin == 7'd0) begin
         data   = {sign, 31'h0};
         status = ST_UNDERFLOW;
      end else begin
         data   = {sign, exp_fin[5:0], frac};
         status = lost ? ST_INEXACT : ST_EXACT;
      end
   end

endmodule

// File: rtl/int_to_fp_converter.sv
// Sequential int32 -> float converter, one normalise shift per cycle.
// Ports: clock_100kHz, reset, start_in, int_in -> busy, done, data_out,
// status_out. Build option ROUND_NEAREST_EN selects rounding in fp_pack.
module int_to_fp_converter
   import fp_pkg::*;
#(
   parameter int BIAS = 31
) (
   input  logic        clock_100kHz,
   input  logic        reset,
   input  logic        start_in,
   input  logic [31:0] int_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_out,
   output logic [3:0]  status_out
);

   cvt_state_e  state;
   cvt_state_e  nxt;
   logic [31:0] int_q;
   logic        sign_q;
   logic [31:0] mag_q;
   logic [4:0]  shift_q;
   logic [31:0] pk_data;
   status_e     pk_status;

   fp_pack #(.BIAS(BIAS)) u_pack (
      .sign      (sign_q),
      .mag       (mag_q),
      .shift_cnt (shift_q),
      .data      (pk_data),
      .status    (pk_status)
   );

   always_ff @(posedge clock_100kHz) begin
      if (reset) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: if (start_in) nxt = S_ABS;
         S_ABS:  nxt = (int_q == '0) ? S_PACK : S_NORM;
         S_NORM: if (mag_q[31]) nxt = S_PACK;
         S_PACK: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_100kHz) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         status_out <= '0;
         int_q      <= '0;
         sign_q     <= 1'b0;
         mag_q      <= '0;
         shift_q    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start_in) begin
                  int_q <= int_in;
                  busy  <= 1'b1;
               end
            end
            S_ABS: begin
               sign_q  <= int_q[31];
               // -2^31 negates to itself, which is the right unsigned mag
               mag_q   <= int_q[31] ? (~int_q + 32'd1) : int_q;
               shift_q <= '0;
            end
            S_NORM: begin
               if (!mag_q[31]) begin
                  mag_q   <= mag_q << 1;
                  shift_q <= shift_q + 5'd1;
               end
            end
            S_PACK: begin
               data_out   <= pk_data;
               status_out <= pk_status;
               done       <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Self-checking bench for int_to_fp_converter (BIAS 31, 40 and 0).
// Table vectors, control sequences and randomised model comparison.
module tb_int_to_fp_converter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_in;
   logic [31:0] int_in;
   logic        busy, done;
   logic [31:0] data_out;
   logic [3:0]  status_out;

   logic        start2;
   logic [31:0] int2;
   logic        busy40, done40, busy0, done0;
   logic [31:0] data40, data0;
   logic [3:0]  st40, st0;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   int_to_fp_converter dut (
      .clock_100kHz (clk),
      .reset        (rst),
      .start_in     (start_in),
      .int_in       (int_in),
      .busy         (busy),
      .done         (done),
      .data_out     (data_out),
      .status_out   (status_out)
   );

   int_to_fp_converter #(.BIAS(40)) dut40 (
      .clock_100kHz (clk),
      .reset        (rst),
      .start_in     (start2),
      .int_in       (int2),
      .busy         (busy40),
      .done         (done40),
      .data_out     (data40),
      .status_out   (st40)
   );

   int_to_fp_converter #(.BIAS(0)) dut0 (
      .clock_100kHz (clk),
      .reset        (rst),
      .start_in     (start2),
      .int_in       (int2),
      .busy         (busy0),
      .done         (done0),
      .data_out     (data0),
      .status_out   (st0)
   );

   typedef struct {
      logic [31:0] v;
      logic [31:0] d;
      logic [3:0]  s;
      int          lat;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Value-level reference: value = 1.f * 2^p scaled into the format.
   function automatic void model(input logic [31:0] v, input int bias,
                                 output logic [31:0] d,
                                 output logic [3:0] s, output int lat);
      longint unsigned m, r, num, fr, rem, one_p;
      int p, e;
      logic sg;
      sg = v[31];
      m  = {32'd0, v};
      if (sg) m = 64'h1_0000_0000 - m;
      if (m == 0) begin
         d = '0; s = 4'd0; lat = 2;
         return;
      end
      p = 0;
      for (int i = 0; i < 32; i++)
         if (m >= (64'd1 << i)) p = i;
      one_p = 64'd1 << p;
      r   = m - one_p;
      num = r << 25;
      fr  = num / one_p;
      rem = num % one_p;
      e   = bias + p;
`ifdef ROUND_NEAREST_EN
      if (2 * rem > one_p || (2 * rem == one_p && fr[0])) fr = fr + 1;
      if (fr == (64'd1 << 25)) begin
         fr = 0;
         e  = e + 1;
      end
`endif
      if (e >= 63) begin
         d = {sg, 6'h3F, 25'h0}; s = 4'd1;
      end else if (e == 0) begin
         d = {sg, 31'h0}; s = 4'd2;
      end else begin
         d = {sg, 6'(e), 25'(fr)};
         s = (rem != 0) ? 4'd3 : 4'd0;
      end
      lat = 34 - p;
   endfunction

   task automatic run(input logic [31:0] v, output logic [31:0] d,
                      output logic [3:0] s, output int lat);
      bit to;
      start_in = 1'b1;
      int_in   = v;
      @(posedge clk); #1;
      start_in = 1'b0;
      int_in   = $urandom;
      lat = 0;
      to  = 1'b0;
      forever begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
         if (lat > 50) begin
            to = 1'b1;
            break;
         end
      end
      if (to) check("timeout", 32'(to), 32'd0);
      d = data_out;
      s = status_out;
   endtask

   task automatic run_vs_model(input logic [31:0] v, input string nm);
      logic [31:0] d, ed;
      logic [3:0]  s, es;
      int lat, el;
      model(v, 31, ed, es, el);
      run(v, d, s, lat);
      check({nm, "_data"}, d, ed);
      check({nm, "_stat"}, 32'(s), 32'(es));
      check({nm, "_lat"}, 32'(lat), 32'(el));
   endtask

   task automatic run2(input logic [31:0] v);
      logic [31:0] ed;
      logic [3:0]  es;
      int el, n;
      start2 = 1'b1;
      int2   = v;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (!done40 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("b40_to", 32'(done40), 32'd1);
      model(v, 40, ed, es, el);
      check("b40_data", data40, ed);
      check("b40_stat", 32'(st40), 32'(es));
      model(v, 0, ed, es, el);
      check("b0_done", 32'(done0), 32'd1);
      check("b0_data", data0, ed);
      check("b0_stat", 32'(st0), 32'(es));
   endtask

   initial begin
      vec_t tbl[7];
      logic [31:0] d, v;
      logic [3:0]  s;
      int lat, nd;

      tbl[0] = '{32'h0000_0001, 32'h3E00_0000, 4'd0, 34};
      tbl[1] = '{32'hFFFF_FFFF, 32'hBE00_0000, 4'd0, 34};
      tbl[2] = '{32'h8000_0000, 32'hFC00_0000, 4'd0, 3};
`ifdef ROUND_NEAREST_EN
      tbl[3] = '{32'h7FFF_FFFF, 32'h7C00_0000, 4'd3, 4};
`else
      tbl[3] = '{32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'd3, 4};
`endif
      tbl[4] = '{32'h0000_0000, 32'h0000_0000, 4'd0, 2};
      tbl[5] = '{32'h0000_0003, 32'h4100_0000, 4'd0, 33};
      tbl[6] = '{32'hFFFF_FFFD, 32'hC100_0000, 4'd0, 33};

      rst = 1'b1; start_in = 1'b0; int_in = '0;
      start2 = 1'b0; int2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", data_out, 32'd0);
      check("rst_stat", 32'(status_out), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         run(tbl[i].v, d, s, lat);
         check($sformatf("tbl%0d_data", i), d, tbl[i].d);
         check($sformatf("tbl%0d_stat", i), 32'(s), 32'(tbl[i].s));
         check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      end

      // second start while busy is dropped
      start_in = 1'b1; int_in = 32'h1;
      @(posedge clk); #1;
      start_in = 1'b0;
      check("busy_on", 32'(busy), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      start_in = 1'b1; int_in = 32'h8000_0000;
      @(posedge clk); #1;
      start_in = 1'b0;
      nd = 0; d = '0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done) begin
            nd++;
            d = data_out;
         end
      end
      check("ign_ndone", 32'(nd), 32'd1);
      check("ign_data", d, 32'h3E00_0000);

      // reset mid-NORM abandons the conversion
      start_in = 1'b1; int_in = 32'h1;
      @(posedge clk); #1;
      start_in = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_data", data_out, 32'd0);
      check("mid_stat", 32'(status_out), 32'd0);
      rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      check("mid_nodone", 32'(nd), 32'd0);
      run_vs_model(32'h7FFF_FFFF, "post_rst");

      // back-to-back, then done must drop while data holds
      run_vs_model(32'h8000_0000, "b2b_a");
      run_vs_model(32'h0001_0000, "b2b_b");
      @(posedge clk); #1;
      check("pulse_done", 32'(done), 32'd0);
      check("hold_data", data_out, 32'h5E00_0000);

      // BIAS 40 overflow and BIAS 0 underflow boundaries
      run2(32'h4000_0000);
      run2(32'h0080_0000);
      run2(32'h0040_0000);
      run2(32'h0000_0001);
      run2(32'hFFFF_FFFF);
      run2(32'h0000_0000);
      repeat (8) run2($urandom);

      for (int i = 0; i < 300; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) v = -v;
         run_vs_model(v, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
